// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron training pipeline: default feature
// geometry, the sample feeder state encoding and the stored sample record.
package perceptron_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int N_INPUTS   = 2;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_RES,
    DONE
  } feeder_state_t;

  // Features occupy the low bits (feature 0 lowest), label sits on top.
  typedef struct packed {
    logic                                label;
    logic [N_INPUTS-1:0][DATA_WIDTH-1:0] x;
  } sample_t;

endpackage

// File: rtl/training_sample_feeder_if.sv
// Bundle between the sample feeder and its environment: register-file
// loading, start control, the sample valid/ready stream, the trainer's
// per-sample verdict and the run status.
interface training_sample_feeder_if #(
  parameter int N_INPUTS   = perceptron_pkg::N_INPUTS,
  parameter int DATA_WIDTH = perceptron_pkg::DATA_WIDTH,
  parameter int IDX_W      = 2,
  parameter int EP_W       = 5
);
  logic                           load_en_i;
  logic [IDX_W-1:0]               load_addr_i;
  logic [N_INPUTS*DATA_WIDTH-1:0] load_x_i;
  logic                           load_label_i;
  logic                           start_i;
  logic                           sample_valid_o;
  logic                           sample_ready_i;
  logic [N_INPUTS*DATA_WIDTH-1:0] sample_x_o;
  logic                           sample_label_o;
  logic [IDX_W-1:0]               sample_idx_o;
  logic                           last_o;
  logic                           result_valid_i;
  logic                           result_err_i;
  logic [EP_W-1:0]                epoch_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           converged_o;

  // Feeder side.
  modport master (
    input  load_en_i, load_addr_i, load_x_i, load_label_i, start_i,
           sample_ready_i, result_valid_i, result_err_i,
    output sample_valid_o, sample_x_o, sample_label_o, sample_idx_o, last_o,
           epoch_o, busy_o, done_o, converged_o
  );

  // Loader / trainer side.
  modport slave (
    output load_en_i, load_addr_i, load_x_i, load_label_i, start_i,
           sample_ready_i, result_valid_i, result_err_i,
    input  sample_valid_o, sample_x_o, sample_label_o, sample_idx_o, last_o,
           epoch_o, busy_o, done_o, converged_o
  );
endinterface

// File: rtl/sample_regfile.sv
// Training-set storage: one sample_t per entry, synchronous write,
// combinational read.
module sample_regfile
  import perceptron_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  sample_t          wdata,
  input  logic [IDX_W-1:0] raddr,
  output sample_t          rdata
);

  sample_t mem [N_SAMPLES];

  // Write port.
  // NOTE: storage arrays carry no reset; the training set must survive a
  // reset, and resetting an array forces it out of RAM-style storage.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/training_sample_feeder.sv
// Streams the stored training set to the trainer one sample at a time,
// epoch after epoch, until an epoch finishes without error or the epoch
// budget is spent.
module training_sample_feeder #(
  parameter  int N_INPUTS   = perceptron_pkg::N_INPUTS,
  parameter  int DATA_WIDTH = perceptron_pkg::DATA_WIDTH,
  parameter  int N_SAMPLES  = 4,
  parameter  int N_EPOCHS   = 16,
  localparam int IDX_W      = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  localparam int EP_W       = $clog2(N_EPOCHS + 1)
) (
  input logic                     clk_i,
  input logic                     reset_i,
  training_sample_feeder_if.master bus
);
  import perceptron_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [EP_W-1:0]  EP_ONE   = EP_W'(1);
  localparam logic [EP_W-1:0]  EP_MAX   = EP_W'(N_EPOCHS);

  feeder_state_t    state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [EP_W-1:0]  epoch, epoch_n;
  logic             ep_err, ep_err_n;
  logic             converged, converged_n;
  logic             err_so_far;
  logic             rf_we;
  sample_t          rf_wdata, rf_rdata;

  // Loads only while stopped; a simultaneous start takes priority.
  assign rf_we = ((state == IDLE) || (state == DONE)) && bus.load_en_i &&
                 !bus.start_i && (int'(bus.load_addr_i) < N_SAMPLES);
  assign rf_wdata = sample_t'({bus.load_label_i, bus.load_x_i});

  // Read the entry that will be presented next so the outputs can be
  // registered on the same edge that moves the index.
  sample_regfile #(
    .N_SAMPLES(N_SAMPLES),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk_i(clk_i),
    .we   (rf_we),
    .waddr(bus.load_addr_i),
    .wdata(rf_wdata),
    .raddr(idx_n),
    .rdata(rf_rdata)
  );

  assign err_so_far = ep_err | bus.result_err_i;

  // Next-state, index, epoch and error-flag logic.
  // NOTE: every target gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    epoch_n     = epoch;
    ep_err_n    = ep_err;
    converged_n = converged;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_n     = PRESENT;
          idx_n       = '0;
          epoch_n     = '0;
          ep_err_n    = 1'b0;
          converged_n = 1'b0;
        end
      end
      PRESENT: begin
        if (bus.sample_ready_i) state_n = WAIT_RES;
      end
      WAIT_RES: begin
        if (bus.result_valid_i) begin
          if (idx != LAST_IDX) begin
            idx_n    = idx + IDX_ONE;
            ep_err_n = err_so_far;
            state_n  = PRESENT;
          end else if (!err_so_far) begin
            converged_n = 1'b1;
            state_n     = DONE;
          end else if (epoch + EP_ONE == EP_MAX) begin
            epoch_n  = epoch + EP_ONE;
            ep_err_n = 1'b1;
            state_n  = DONE;
          end else begin
            epoch_n  = epoch + EP_ONE;
            ep_err_n = 1'b0;
            idx_n    = '0;
            state_n  = PRESENT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers and registered stream/status outputs.
  // NOTE: non-blocking assignments so every register samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state              <= IDLE;
      idx                <= '0;
      epoch              <= '0;
      ep_err             <= 1'b0;
      converged          <= 1'b0;
      bus.sample_valid_o <= 1'b0;
      bus.sample_x_o     <= '0;
      bus.sample_label_o <= 1'b0;
      bus.last_o         <= 1'b0;
      bus.busy_o         <= 1'b0;
      bus.done_o         <= 1'b0;
    end else begin
      state              <= state_n;
      idx                <= idx_n;
      epoch              <= epoch_n;
      ep_err             <= ep_err_n;
      converged          <= converged_n;
      bus.sample_valid_o <= (state_n == PRESENT);
      bus.last_o         <= (state_n == PRESENT) && (idx_n == LAST_IDX);
      bus.busy_o         <= (state_n == PRESENT) || (state_n == WAIT_RES);
      bus.done_o         <= (state_n == DONE);
      if (state_n == PRESENT) begin
        bus.sample_x_o     <= rf_rdata.x;
        bus.sample_label_o <= rf_rdata.label;
      end
    end
  end

  assign bus.sample_idx_o = idx;
  assign bus.epoch_o      = epoch;
  assign bus.converged_o  = converged;

endmodule
